// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants and the IF PC-stage FSM state type.
//   ADDR_WIDTH  default PC/target width
//   INSTR_BYTES bytes per instruction (sequential PC step)
//   pc_state_e  IDLE / RUN / HALT
package mips_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_e;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC selection for the fetch stage.
//   in : pc, pc_plus4, branch_target, jump_target, pc_src, jump, stall, halt
//   out: next_pc (halt > branch > jump > stall > pc+4, targets word-masked),
//        redirect (branch or jump taken), misaligned (selected target bits [1:0] != 0)
module pc_next_mux import mips_pkg::*; #(
  parameter int AW = ADDR_WIDTH
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] pc_plus4,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] jump_target,
  input  logic          pc_src,
  input  logic          jump,
  input  logic          stall,
  input  logic          halt,
  output logic [AW-1:0] next_pc,
  output logic          redirect,
  output logic          misaligned
);
  logic [AW-1:0] target;
  always_comb begin
    target = pc_src ? branch_target : jump_target;
    redirect = !halt && (pc_src || jump);
    misaligned = target[1:0] != 2'b00;
    // A redirect wins over a stall: the hazard being stalled on belongs to the squashed path.
    next_pc = halt ? pc : redirect ? {target[AW-1:2], 2'b00} : stall ? pc : pc_plus4;
  end
endmodule

// File: rtl/if_pc_stage.sv
// if_pc_stage: instruction-fetch PC register with IDLE/RUN/HALT control.
//   in : i_clk, i_rst_n (sync, active-low), i_start, i_pc_src, i_branch_target,
//        i_jump, i_jump_target, i_stall, i_halt
//   out: o_pc, o_pc_plus4, o_valid, o_if_id_flush, o_halted, o_fetch_count, o_align_err
//   Macro IF_PC_ALIGN_CHECK_EN: misaligned redirect targets set sticky o_align_err and halt;
//   when undefined targets are only masked and o_align_err stays 0.
module if_pc_stage import mips_pkg::*; #(
  parameter int                    ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_pc_src,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_target,
  input  logic                  i_stall,
  input  logic                  i_halt,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic                  o_valid,
  output logic                  o_if_id_flush,
  output logic                  o_halted,
  output logic [31:0]           o_fetch_count,
  output logic                  o_align_err
);
`ifdef IF_PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  pc_state_e state;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic redirect, misaligned, run, fault;
  assign run = state == RUN;
  assign fault = ALIGN_EN && redirect && misaligned;
  assign o_pc_plus4 = o_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign o_valid = run;
  assign o_halted = state == HALT;
  pc_next_mux #(.AW(ADDR_WIDTH)) u_mux (
    .pc            (o_pc),
    .pc_plus4      (o_pc_plus4),
    .branch_target (i_branch_target),
    .jump_target   (i_jump_target),
    .pc_src        (i_pc_src),
    .jump          (i_jump),
    .stall         (i_stall),
    .halt          (i_halt),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_pc <= RESET_PC;
      o_if_id_flush <= 1'b0;
      o_fetch_count <= 32'd0;
      o_align_err <= 1'b0;
    end else begin
      o_if_id_flush <= run && redirect;
      if (state == IDLE && i_start) state <= RUN;
      if (run) begin
        o_pc <= next_pc;
        if (next_pc != o_pc) o_fetch_count <= o_fetch_count + 32'd1;
        if (i_halt || fault) state <= HALT;
        if (fault) o_align_err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/if_pc_stage.md
IF_PC_STAGE -- requirements
Module: if_pc_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC/target width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port i_pc_src  input  1  branch taken (zero-flag AND branch control from the branch-decision gate).
REQ-007 SHALL have port i_branch_target  input  ADDR_WIDTH  branch destination.
REQ-008 SHALL have port i_jump  input  1  jump decoded in ID.
REQ-009 SHALL have port i_jump_target  input  ADDR_WIDTH  jump destination.
REQ-010 SHALL have port i_stall  input  1  hazard-unit stall request for PC and IF/ID.
REQ-011 SHALL have port i_halt  input  1  halt instruction detected.
REQ-012 SHALL have port o_pc  output  ADDR_WIDTH  current fetch address to instruction memory.
REQ-013 SHALL have port o_pc_plus4  output  ADDR_WIDTH  o_pc + 4, for IF/ID.
REQ-014 SHALL have port o_valid  output  1  o_pc is a valid fetch this cycle.
REQ-015 SHALL have port o_if_id_flush  output  1  one-cycle pulse, insert bubble in IF/ID.
REQ-016 SHALL have port o_halted  output  1  stage in HALT.
REQ-017 SHALL have port o_fetch_count  output  32  number of PC advances since reset.
REQ-018 SHALL have port o_align_err  output  1  sticky misaligned-target flag.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN on i_start; RUN->HALT on i_halt; HALT left only by reset.
REQ-020 SHALL hold o_pc and assert o_valid=0 in IDLE and HALT; o_valid=1 in RUN.
REQ-021 SHALL, in RUN, select next PC with priority: i_halt (hold) > i_pc_src (branch target) > i_jump (jump target) > i_stall (hold) > o_pc+4.
REQ-022 SHALL let a redirect (branch or jump) override a simultaneous i_stall.
REQ-023 SHALL register o_if_id_flush=1 for exactly one cycle after a taken redirect; 0 otherwise.
REQ-024 SHALL compute o_pc_plus4 combinationally from o_pc, modulo 2^ADDR_WIDTH (0xFFFF_FFFC+4 -> 0x0).
REQ-025 SHALL increment o_fetch_count by 1 on every RUN cycle where o_pc changes (redirect or sequential), wrapping at 2^32.
REQ-026 SHALL force bits [1:0] of any loaded target to 00.
REQ-027 SHALL ignore i_pc_src, i_jump, i_stall in IDLE and HALT.

Reset
REQ-028 SHALL, when i_rst_n=0 at a rising edge, set state=IDLE, o_pc=RESET_PC, o_if_id_flush=0, o_fetch_count=0, o_align_err=0, regardless of state or pending redirect.

Configuration
REQ-029 SHALL support macro IF_PC_ALIGN_CHECK_EN: when defined, a redirect target with bits [1:0]!=00 sets o_align_err=1 (sticky until reset) and moves FSM to HALT the following cycle, PC loaded with masked target; when undefined, masking only and o_align_err tied 0.

Structure
REQ-030 SHALL take ADDR_WIDTH default, INSTR_BYTES=4 and the FSM state enum from shared package mips_pkg.
REQ-031 SHALL place next-PC selection in combinational sub-module pc_next_mux; state, PC register, counters in if_pc_stage.

Verification
REQ-032 Reset, i_start=1, 3 free cycles -> o_pc 0x0,0x4,0x8,0xC; o_fetch_count=3; o_valid=1.
REQ-033 At o_pc=0x10 pulse i_pc_src=1, i_branch_target=0x40 -> next o_pc=0x40, o_if_id_flush=1 one cycle, then 0x44.
REQ-034 i_pc_src=1 (0x80) and i_jump=1 (0x200) and i_stall=1 same cycle -> o_pc=0x80, flush pulse.
REQ-035 i_stall=1 for 2 cycles at o_pc=0x20 -> o_pc stays 0x20, count unchanged, no flush; then 0x24.
REQ-036 i_halt=1 at o_pc=0x30 -> o_halted=1, o_pc held 0x30 for 10 cycles despite i_jump; i_rst_n=0 -> IDLE, o_pc=0x0, count=0.
REQ-037 With IF_PC_ALIGN_CHECK_EN, jump target 0x102 -> o_pc=0x100, o_align_err=1, o_halted=1 next cycle; without macro -> o_pc=0x100, continues 0x104, o_align_err=0.
